// File: rtl/boolean_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : boolean_pkg
//  Description : Shared constants for the boolean_* truth-table sweep checker:
//                default DUT input count, default dwell time, FSM state
//                encoding and a counter-width helper.
//  Contents    : N_IN_DEFAULT, SETTLE_DEFAULT, S_IDLE/S_SETTLE/S_DONE,
//                cnt_width()
//  Revision    : 1.0 - initial release
// ============================================================================
package boolean_pkg;

  localparam int N_IN_DEFAULT   = 3;
  localparam int SETTLE_DEFAULT = 4;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  // A one-cycle dwell still needs a 1-bit counter register.
  function automatic int cnt_width(input int settle);
    return (settle > 1) ? $clog2(settle) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/boolean_sweep_checker_sweep_timer.sv
`default_nettype none
// ============================================================================
//  Module      : sweep_timer
//  Description : Dwell down-counter. A load presets SETTLE-1; while enabled
//                the count drops by one per edge and parks at zero. Terminal
//                count marks the edge on which the current vector is sampled.
//  Ports       : clk     - clock, rising edge
//                rst_n   - asynchronous active-low reset
//                load_i  - preset the count to SETTLE-1 (wins over en_i)
//                en_i    - count down
//                tc_o    - count is zero
//  Revision    : 1.0 - initial release
// ============================================================================
module sweep_timer
  import boolean_pkg::*;
#(
  parameter int SETTLE = SETTLE_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int            CW       = cnt_width(SETTLE);
  localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/boolean_sweep_checker.sv
`default_nettype none
// ============================================================================
//  Module      : boolean_sweep_checker
//  Description : Exhaustive truth-table checker for an N_IN-input single-output
//                combinational block. Drives every input vector for SETTLE
//                cycles, samples the block output at the end of each dwell,
//                builds the captured table and compares it with an expected
//                table latched at start.
//  Ports       : clk            - clock, rising edge
//                rst_n          - asynchronous active-low reset
//                start_i        - begin a sweep (honoured only when idle)
//                expected_i     - expected table, bit i for vector i
//                vec_out_o      - vector driven into the block under test
//                d_in_i         - output of the block under test
//                table_out_o    - captured table, bit i for vector i
//                busy_o         - sweep in progress
//                done_o         - one-cycle pulse at sweep end
//                pass_o         - captured table equals expected table
//                mismatch_cnt_o - number of differing table bits
//  Revision    : 1.0 - initial release
// ============================================================================
module boolean_sweep_checker
  import boolean_pkg::*;
#(
  parameter int N_IN   = N_IN_DEFAULT,
  parameter int SETTLE = SETTLE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [2**N_IN-1:0]   expected_i,
  output logic [N_IN-1:0]      vec_out_o,
  input  logic                 d_in_i,
  output logic [2**N_IN-1:0]   table_out_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic [N_IN:0]        mismatch_cnt_o
);

  localparam int              TW       = 2**N_IN;
  localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};
  localparam logic [N_IN-1:0] VEC_ONE  = N_IN'(1);
  localparam logic [N_IN:0]   MM_ONE   = (N_IN + 1)'(1);

  logic [1:0]      state_q, state_d;
  logic [N_IN-1:0] vec_q,   vec_d;
  logic [TW-1:0]   table_q, table_d;
  logic [TW-1:0]   exp_q,   exp_d;
  logic            busy_q,  busy_d;
  logic            done_q,  done_d;
  logic            pass_q,  pass_d;
  logic [N_IN:0]   mm_q,    mm_d;

  logic            timer_load;
  logic            timer_en;
  logic            timer_tc;

  sweep_timer #(
    .SETTLE (SETTLE)
  ) u_sweep_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (timer_load),
    .en_i   (timer_en),
    .tc_o   (timer_tc)
  );

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    table_d    = table_q;
    exp_d      = exp_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    mm_d       = mm_q;
    timer_load = 1'b0;
    timer_en   = 1'b0;

    case (state_q)
      S_IDLE: begin
        done_d = 1'b0;
        if (start_i) begin
          exp_d      = expected_i;
          table_d    = '0;
          pass_d     = 1'b0;
          mm_d       = '0;
          vec_d      = '0;
          busy_d     = 1'b1;
          timer_load = 1'b1;
          state_d    = S_SETTLE;
        end
      end

      S_SETTLE: begin
        timer_en = 1'b1;
        // Terminal count is the last edge of this vector's dwell.
        if (timer_tc) begin
          table_d[vec_q] = d_in_i;
          if (d_in_i != exp_q[vec_q]) begin
            mm_d = mm_q + MM_ONE;
          end
          if (vec_q == VEC_LAST) begin
            // vec_out stays at the last vector until the next start.
            state_d = S_DONE;
          end else begin
            vec_d      = vec_q + VEC_ONE;
            timer_load = 1'b1;
          end
        end
      end

      S_DONE: begin
        // The mismatch count is final here, so pass is derived from it now.
        done_d  = 1'b1;
        busy_d  = 1'b0;
        pass_d  = (mm_q == '0);
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      table_q <= '0;
      exp_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      mm_q    <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      table_q <= table_d;
      exp_q   <= exp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      mm_q    <= mm_d;
    end
  end

  assign vec_out_o      = vec_q;
  assign table_out_o    = table_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign pass_o         = pass_q;
  assign mismatch_cnt_o = mm_q;

endmodule
`default_nettype wire

// File: tb/tb_boolean_sweep_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_boolean_sweep_checker
//  Description : Self-checking bench for boolean_sweep_checker. Two checker
//                instances: default (SETTLE=4) driving a selectable behavioural
//                block, and SETTLE=1 driving d = ~a. Expected tables come from
//                a behavioural model and travel through a scoreboard queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_boolean_sweep_checker;

  typedef struct packed {
    logic [7:0] tbl;
    logic       pss;
    logic [3:0] mm;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start1 = 1'b0;
  logic       start2 = 1'b0;
  logic [7:0] exp1 = '0;
  logic [7:0] exp2 = '0;
  int         mode = 0;

  logic [2:0] vec1, vec2;
  logic       d1, d2;
  logic [7:0] tbl1, tbl2;
  logic       busy1, busy2, done1, done2, pass1, pass2;
  logic [3:0] mm1, mm2;

  exp_t sb[$];
  int   passed = 0;
  int   failed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  // Behavioural 3-input blocks: 0 = a&b&c, 1 = a^b^c, 2 = ~a.
  function automatic logic model_f(input int m, input logic [2:0] v);
    case (m)
      0:       return &v;
      1:       return ^v;
      default: return ~v[2];
    endcase
  endfunction

  assign d1 = model_f(mode, vec1);
  assign d2 = ~vec2[2];

  boolean_sweep_checker u_dut1 (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (start1),
    .expected_i     (exp1),
    .vec_out_o      (vec1),
    .d_in_i         (d1),
    .table_out_o    (tbl1),
    .busy_o         (busy1),
    .done_o         (done1),
    .pass_o         (pass1),
    .mismatch_cnt_o (mm1)
  );

  boolean_sweep_checker #(.N_IN(3), .SETTLE(1)) u_dut2 (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (start2),
    .expected_i     (exp2),
    .vec_out_o      (vec2),
    .d_in_i         (d2),
    .table_out_o    (tbl2),
    .busy_o         (busy2),
    .done_o         (done2),
    .pass_o         (pass2),
    .mismatch_cnt_o (mm2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [2:0] vec_of(input int sel);
    return (sel == 1) ? vec2 : vec1;
  endfunction
  function automatic logic done_of(input int sel);
    return (sel == 1) ? done2 : done1;
  endfunction
  function automatic logic busy_of(input int sel);
    return (sel == 1) ? busy2 : busy1;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_vec1"},  32'(vec1),  0);
    chk({tag, "_tbl1"},  32'(tbl1),  0);
    chk({tag, "_busy1"}, 32'(busy1), 0);
    chk({tag, "_done1"}, 32'(done1), 0);
    chk({tag, "_pass1"}, 32'(pass1), 0);
    chk({tag, "_mm1"},   32'(mm1),   0);
    chk({tag, "_vec2"},  32'(vec2),  0);
    chk({tag, "_tbl2"},  32'(tbl2),  0);
    chk({tag, "_busy2"}, 32'(busy2), 0);
    chk({tag, "_done2"}, 32'(done2), 0);
  endtask

  // One full sweep on instance sel (0: SETTLE=4, 1: SETTLE=1). With poke set,
  // start is pulsed again mid-sweep and must have no effect.
  task automatic run(input int sel, input logic [7:0] e, input int m, input bit poke);
    exp_t       want;
    int         settle;
    int         lat;
    int         vec_bad;
    int         extra;
    int         ev;
    logic [7:0] tbl;
    settle = (sel == 1) ? 1 : 4;
    for (int v = 0; v < 8; v++) tbl[v] = model_f(m, 3'(v));
    want.tbl = tbl;
    want.mm  = 4'($countones(tbl ^ e));
    want.pss = (want.mm == 4'd0);
    sb.push_back(want);

    if (sel == 1) exp2 = e;
    else begin
      exp1 = e;
      mode = m;
    end
    @(negedge clk);
    if (sel == 1) start2 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    start2 = 1'b0;
    chk($sformatf("busy_start_d%0d", sel + 1), 32'(busy_of(sel)), 1);
    chk($sformatf("vec_start_d%0d", sel + 1), 32'(vec_of(sel)), 0);

    lat     = -1;
    vec_bad = 0;
    for (int j = 1; (j <= 80) && (lat < 0); j++) begin
      @(negedge clk);
      if (poke && j == 10) start1 = 1'b1;
      if (poke && j == 11) start1 = 1'b0;
      ev = j / settle;
      if (ev > 7) ev = 7;
      if (vec_of(sel) !== 3'(ev)) vec_bad++;
      if (done_of(sel) === 1'b1) lat = j;
    end
    chk($sformatf("done_latency_d%0d", sel + 1), 32'(lat), 32'(8 * settle + 1));
    chk($sformatf("vec_sequence_d%0d", sel + 1), 32'(vec_bad), 0);
    chk($sformatf("busy_end_d%0d", sel + 1), 32'(busy_of(sel)), 0);

    want = sb.pop_front();
    if (sel == 1) begin
      chk("table_d2", 32'(tbl2), 32'(want.tbl));
      chk("pass_d2",  32'(pass2), 32'(want.pss));
      chk("mm_d2",    32'(mm2),  32'(want.mm));
    end else begin
      chk("table_d1", 32'(tbl1), 32'(want.tbl));
      chk("pass_d1",  32'(pass1), 32'(want.pss));
      chk("mm_d1",    32'(mm1),  32'(want.mm));
    end

    @(negedge clk);
    chk($sformatf("done_drop_d%0d", sel + 1), 32'(done_of(sel)), 0);
    chk($sformatf("vec_hold_d%0d", sel + 1), 32'(vec_of(sel)), 7);
    chk($sformatf("pass_hold_d%0d", sel + 1), 32'((sel == 1) ? pass2 : pass1), 32'(want.pss));

    if (poke) begin
      extra = 0;
      repeat (40) begin
        @(negedge clk);
        if (done1 === 1'b1 || busy1 === 1'b1) extra++;
      end
      chk("no_requeue", 32'(extra), 0);
    end
  endtask

  initial begin
    exp_t aborted;
    // Reset held, then released with start low.
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    chk_zero("reset_hold");
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk_zero("idle_after_reset");

    // AND block, matching and one-off expected tables; XOR block.
    run(0, 8'h80, 0, 1'b0);
    run(0, 8'h81, 0, 1'b0);
    run(0, 8'h80, 1, 1'b0);

    // Start pulse during an active sweep.
    run(0, 8'h80, 0, 1'b1);

    // Reset during vector 3 of an XOR sweep, after bits 1 and 2 were captured.
    mode  = 1;
    exp1  = 8'h80;
    aborted.tbl = 8'h00;
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (13) @(negedge clk);
    chk("pre_reset_vec", 32'(vec1), 3);
    chk("pre_reset_tbl", 32'(tbl1), 32'(8'h06));
    chk("pre_reset_mm",  32'(mm1),  2);
    #2 rst_n = 1'b0;
    #1 chk_zero("async_reset");
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero("after_abort");
    run(0, 8'h96, 1, 1'b0);

    // SETTLE=1 instance with d = ~a.
    run(1, 8'h0F, 2, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
    $fatal(1);
  end

endmodule
`default_nettype wire
